// File: rtl/toggle_event_monitor.sv
// Watches a toggle-encoded event line: one evt pulse per level change, a saturating
// event count with sticky overflow flag, and an idle indication after a quiet period.
module toggle_event_monitor #(
   parameter int IDLE_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tog,
   input  logic       clear,
   output logic       evt,
   output logic [7:0] count,
   output logic       sat,
   output logic       idle
);

   localparam logic [3:0] LIMIT = 4'(IDLE_LIMIT);

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      ACTIVE = 2'd1,
      IDLE   = 2'd2
   } state_t;

   state_t     state, state_next;
   logic       tog_q;
   logic       event_hit;
   logic [3:0] quiet, quiet_next;
   logic [7:0] count_next;
   logic       sat_next;
   logic       evt_next;
   logic       idle_next;

   always_comb begin
      event_hit  = (tog != tog_q);
      state_next = state;
      count_next = count;
      sat_next   = sat;
      quiet_next = quiet;
      evt_next   = event_hit;
      idle_next  = 1'b0;

      // Clear wins over counting, but a coincident event is still counted as the first.
      if (clear) begin
         count_next = event_hit ? 8'd1 : 8'd0;
         sat_next   = 1'b0;
         quiet_next = 4'd0;
         state_next = event_hit ? ACTIVE : WAIT;
      end else if (event_hit) begin
         quiet_next = 4'd0;
         state_next = ACTIVE;
         if (count == 8'hFF) begin
            sat_next = 1'b1;
         end else begin
            count_next = count + 8'd1;
         end
      end else begin
         if (quiet != LIMIT) begin
            quiet_next = quiet + 4'd1;
         end
         if (state == ACTIVE && quiet_next == LIMIT) begin
            state_next = IDLE;
         end
      end

      // WAIT also reports idle once the quiet period has elapsed.
      idle_next = (state_next != ACTIVE) && (quiet_next == LIMIT);
   end

   always_ff @(posedge clk) begin
      tog_q <= tog;
      if (reset) begin
         state <= WAIT;
         count <= 8'd0;
         sat   <= 1'b0;
         quiet <= 4'd0;
         evt   <= 1'b0;
         idle  <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         sat   <= sat_next;
         quiet <= quiet_next;
         evt   <= evt_next;
         idle  <= idle_next;
      end
   end

endmodule

// File: tb/tb_toggle_event_monitor.sv
// Scoreboard bench for toggle_event_monitor: stimulus pushes expected per-cycle outputs
// from a behavioural model; a monitor pops and compares on the falling edge.
module tb_toggle_event_monitor;

   localparam int LIM = 15;

   logic       clk;
   logic       reset;
   logic       tog;
   logic       clear;
   logic       evt;
   logic [7:0] count;
   logic       sat;
   logic       idle;

   toggle_event_monitor #(.IDLE_LIMIT(LIM)) dut (
      .clk(clk),
      .reset(reset),
      .tog(tog),
      .clear(clear),
      .evt(evt),
      .count(count),
      .sat(sat),
      .idle(idle)
   );

   typedef struct {
      logic       evt;
      logic [7:0] count;
      logic       sat;
      logic       idle;
      string      tag;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Reference model state
   logic       m_togq;
   logic       m_evt;
   int         m_count;
   logic       m_sat;
   int         m_quiet;
   string      cur_tag = "init";

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic t, input logic c, input logic r);
      exp_t e;
      logic ev;
      tog   = t;
      clear = c;
      reset = r;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_togq  = t;
         m_evt   = 1'b0;
         m_count = 0;
         m_sat   = 1'b0;
         m_quiet = 0;
      end else begin
         ev     = (t != m_togq);
         m_togq = t;
         m_evt  = ev;
         if (c) begin
            m_count = ev ? 1 : 0;
            m_sat   = 1'b0;
            m_quiet = 0;
         end else if (ev) begin
            m_quiet = 0;
            if (m_count == 255) m_sat = 1'b1;
            else m_count = m_count + 1;
         end else if (m_quiet < LIM) begin
            m_quiet = m_quiet + 1;
         end
      end
      e.evt   = m_evt;
      e.count = 8'(m_count);
      e.sat   = m_sat;
      e.idle  = (m_quiet == LIM);
      e.tag   = cur_tag;
      e.cyc   = cyc;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic flip(input logic c);
      step(~tog, c, 1'b0);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(tog, 1'b0, 1'b0);
   endtask

   // Monitor: one comparison per cycle whenever an expectation is pending
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if (evt !== e.evt || count !== e.count || sat !== e.sat || idle !== e.idle) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got evt=%0b count=%0d sat=%0b idle=%0b, want evt=%0b count=%0d sat=%0b idle=%0b",
                     e.tag, e.cyc, evt, count, sat, idle, e.evt, e.count, e.sat, e.idle);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tog   = 1'b1;
      clear = 1'b0;
      reset = 1'b1;

      // Reset with tog=1, release and hold: no events, idle in WAIT after LIM cycles
      cur_tag = "reset_hold";
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      hold(3);
      cur_tag = "wait_idle";
      hold(14);

      // Consecutive toggles 0->1->0->1 give three back-to-back evt pulses
      cur_tag = "toggle_seq";
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      hold(2);

      // Reach count=5, then clear with event, then clear alone
      cur_tag = "clear_evt";
      flip(1'b0);
      flip(1'b0);
      hold(1);
      flip(1'b1);
      hold(1);
      cur_tag = "clear_only";
      step(tog, 1'b1, 1'b0);
      hold(1);

      // One event then quiet period until idle, then an event drops it
      cur_tag = "idle_cycle";
      flip(1'b0);
      hold(16);
      flip(1'b0);
      hold(2);

      // 257 changes saturate count and set sticky sat
      cur_tag = "saturate";
      step(tog, 1'b1, 1'b0);
      for (int i = 0; i < 257; i++) flip(1'b0);
      hold(2);
      cur_tag = "sat_clear_evt";
      flip(1'b1);
      hold(1);

      // Mid-operation reset while idle
      cur_tag = "reset_mid";
      hold(16);
      step(~tog, 1'b0, 1'b1);
      hold(2);

      // Random tog/clear with a reset pulse in the middle
      cur_tag = "random";
      for (int i = 0; i < 50; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              (i == 24 || i == 25));
      end

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/toggle_event_monitor.md
TOGGLE_EVENT_MONITOR -- requirements
Module: toggle_event_monitor

Interface
REQ-001 SHALL have parameter: IDLE_LIMIT, 15, number of consecutive event-free cycles before idle asserts (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: tog  input  1  toggle-encoded event line, driven by the upstream T flip-flop q output; every level change is one event.
REQ-005 SHALL have port: clear  input  1  synchronous clear of count, sat and quiet counter.
REQ-006 SHALL have port: evt  output  1  one-cycle pulse per detected tog change.
REQ-007 SHALL have port: count  output  8  saturating number of events since reset/clear.
REQ-008 SHALL have port: sat  output  1  sticky flag: an event arrived while count was 255.
REQ-009 SHALL have port: idle  output  1  high when no event has occurred for IDLE_LIMIT consecutive cycles.
REQ-010 SHALL have one clock (clk); reset is synchronous and active-high (reset); no other clock or asynchronous input.

Function
REQ-011 SHALL hold a 1-bit copy tog_q of tog, loaded with tog at every rising edge, including during reset.
REQ-012 SHALL define event at an edge as (tog != tog_q) sampled at that edge, with reset low.
REQ-013 SHALL drive evt as a registered output: high for exactly the one cycle following an edge where event is true, otherwise low.
REQ-014 SHALL produce one evt per tog change; a tog that changes every cycle SHALL produce evt high on consecutive cycles.
REQ-015 SHALL increment count by 1 at the same edge that sets evt, when count < 255.
REQ-016 SHALL hold count at 255 on further events and set sat at that edge; sat stays 1 until reset or clear.
REQ-017 SHALL keep a 4-bit quiet counter: reset to 0 on event, otherwise increment, saturating at IDLE_LIMIT.
REQ-018 SHALL drive idle = (quiet == IDLE_LIMIT), registered; an event at an edge SHALL drop idle in the following cycle.
REQ-019 SHALL implement FSM with states WAIT (no event since reset/clear), ACTIVE (event seen, quiet < IDLE_LIMIT), IDLE (quiet == IDLE_LIMIT after at least one event).
REQ-020 SHALL transition WAIT->ACTIVE on event, ACTIVE->IDLE when quiet reaches IDLE_LIMIT, IDLE->ACTIVE on event, any state->WAIT on clear without event.
REQ-021 SHALL assert idle in both WAIT and IDLE when quiet == IDLE_LIMIT; in WAIT, idle SHALL assert after IDLE_LIMIT event-free cycles.
REQ-022 SHALL, on clear with no event, set count=0, sat=0, quiet=0, state WAIT, evt=0 next cycle.
REQ-023 SHALL, on clear with simultaneous event, set count=1, sat=0, quiet=0, state ACTIVE, evt=1 next cycle.
REQ-024 SHALL give reset priority over clear and event; an event coinciding with reset SHALL be discarded.

Reset
REQ-025 SHALL, after an edge with reset high, output evt=0, count=0, sat=0, idle=0, state WAIT, quiet=0, tog_q=tog.
REQ-026 SHALL NOT generate evt on the first edge after reset deasserts if tog was unchanged since the final reset edge.
REQ-027 SHALL accept reset mid-operation at any state with identical result to power-on reset.

Verification
REQ-028 SHALL cover: reset with tog=1, release, hold tog=1 for 3 cycles -> evt=0, count=0 throughout.
REQ-029 SHALL cover: tog toggles 0->1->0->1 on consecutive cycles -> evt high 3 consecutive cycles, count=3.
REQ-030 SHALL cover: 257 tog changes -> count=255, sat=1 after 256th change, evt still pulses each change.
REQ-031 SHALL cover: one event then 15 quiet cycles (IDLE_LIMIT=15) -> idle=1 on cycle 15; next tog change -> idle=0 the cycle after.
REQ-032 SHALL cover: count=5, clear asserted with simultaneous tog change -> count=1, evt=1, sat=0; clear alone -> count=0.
REQ-033 SHALL cover: random tog/clear for 50 cycles with reset pulsed mid-stream -> outputs match cycle-level model of REQ-011..REQ-027.
